// File: rtl/vga_stream_pkg.sv
// vga_stream_pkg
//   Shared definitions for the VGA frame streamer: default pixel width,
//   Avalon-ST video packet type code and the streamer FSM state type.
package vga_stream_pkg;

    localparam int unsigned PIX_W_DEFAULT = 12;

    // Packet type carried in the header beat (video data packet).
    localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PIXELS
    } stream_state_e;

endpackage

// File: rtl/vga_skid_fifo.sv
// vga_skid_fifo
//   Two-entry first-word-fall-through buffer between the frame-store read
//   pipeline and the Avalon-ST output.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push, din  write an entry (ignored when full)
//   pop        remove the head entry (ignored when empty)
//   count      current occupancy, 0..2
//   head       oldest entry, valid while count != 0
module vga_skid_fifo #(
    parameter int unsigned WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] e0_q, e0_d;
    logic [WIDTH-1:0] e1_q, e1_d;
    logic [1:0]       count_q, count_d;

    // Pop first, then place the new entry behind whatever remains, so a
    // simultaneous push/pop keeps order at any occupancy.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        if (pop && (count_q != 2'd0)) begin
            e0_d    = e1_q;
            count_d = count_q - 2'd1;
        end
        if (push && (count_d != 2'd2)) begin
            if (count_d == 2'd0) begin
                e0_d = din;
            end else begin
                e1_d = din;
            end
            count_d = count_d + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= '0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = e0_q;

endmodule

// File: rtl/vga_frame_streamer.sv
// vga_frame_streamer
//   Reads a double-buffered frame store and emits one Avalon-ST video packet
//   per frame (optional header beat, then H_RES*V_RES pixels) toward the VGA
//   output subsystem, with display-bank swapping at frame boundaries.
// Ports:
//   clk_clk, reset_reset          clock, asynchronous active-high reset
//   enable                        stream frames back-to-back while high
//   swap_req / swap_ack           bank toggle request / applied pulse
//   disp_bank                     bank currently displayed
//   rd_en, rd_addr, rd_data       frame-store read port (1-cycle latency)
//   st_data, st_valid, st_sop,
//   st_eop, st_ready              Avalon-ST source toward the VGA subsystem
//   frame_done                    pulse after the EOP beat is accepted
//   busy                          high while a frame is in progress
module vga_frame_streamer
    import vga_stream_pkg::*;
#(
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned PIX_W       = PIX_W_DEFAULT,
    parameter int unsigned ADDR_W      = 19,
    parameter bit          EMIT_HEADER = 1'b1
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              enable,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              disp_bank,
    output logic              rd_en,
    output logic [ADDR_W:0]   rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [PIX_W-1:0]  st_data,
    output logic              st_valid,
    output logic              st_sop,
    output logic              st_eop,
    input  logic              st_ready,
    output logic              frame_done,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_RES * V_RES - 1);

    stream_state_e     state_q, state_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic              rd_done_q, rd_done_d;
    logic              inflight_q, inflight_d;
    logic              inflight_eop_q, inflight_eop_d;
    logic              first_q, first_d;
    logic              disp_bank_q, disp_bank_d;
    logic              swap_pending_q, swap_pending_d;
    logic              swap_ack_q, swap_ack_d;
    logic              frame_done_q, frame_done_d;

    logic              rd_en_c;
    logic              fifo_pop;
    logic [1:0]        fifo_count;
    logic [PIX_W:0]    fifo_head;

    vga_skid_fifo #(
        .WIDTH (PIX_W + 1)
    ) u_skid (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .push  (inflight_q),
        .din   ({inflight_eop_q, rd_data}),
        .pop   (fifo_pop),
        .count (fifo_count),
        .head  (fifo_head)
    );

    always_comb begin
        state_d        = state_q;
        pix_cnt_d      = pix_cnt_q;
        rd_done_d      = rd_done_q;
        first_d        = first_q;
        disp_bank_d    = disp_bank_q;
        swap_pending_d = swap_pending_q | swap_req;
        swap_ack_d     = 1'b0;
        frame_done_d   = 1'b0;
        rd_en_c        = 1'b0;
        fifo_pop       = 1'b0;
        st_valid       = 1'b0;
        st_data        = '0;
        st_sop         = 1'b0;
        st_eop         = 1'b0;

        case (state_q)
            IDLE: begin
                pix_cnt_d = '0;
                rd_done_d = 1'b0;
                first_d   = 1'b1;
                if (enable) begin
                    state_d = EMIT_HEADER ? HEADER : PIXELS;
                    if (swap_pending_q || swap_req) begin
                        disp_bank_d    = ~disp_bank_q;
                        swap_ack_d     = 1'b1;
                        swap_pending_d = 1'b0;
                    end
                end
            end
            HEADER: begin
                st_valid = 1'b1;
                st_sop   = 1'b1;
                st_data  = PIX_W'(PKT_TYPE_VIDEO);
                if (st_ready) begin
                    state_d = PIXELS;
                end
            end
            PIXELS: begin
                st_valid = (fifo_count != 2'd0);
                if (st_valid) begin
                    st_data = fifo_head[PIX_W-1:0];
                    st_eop  = fifo_head[PIX_W];
                    st_sop  = !EMIT_HEADER && first_q;
                end
                fifo_pop = st_valid && st_ready;
                if (fifo_pop) begin
                    first_d = 1'b0;
                    if (fifo_head[PIX_W]) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Issue a read only if buffer plus in-flight data, less this cycle's
        // pop, leaves room; rd_done freezes pix_cnt on the last pixel.
        if ((state_q != IDLE) && !rd_done_q &&
            (({1'b0, fifo_count} + {2'b0, inflight_q}) < (3'd2 + {2'b0, fifo_pop}))) begin
            rd_en_c = 1'b1;
            if (pix_cnt_q == LAST_PIX) begin
                rd_done_d = 1'b1;
            end else begin
                pix_cnt_d = pix_cnt_q + ADDR_W'(1);
            end
        end

        inflight_d     = rd_en_c;
        inflight_eop_d = rd_en_c && (pix_cnt_q == LAST_PIX);
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q        <= IDLE;
            pix_cnt_q      <= '0;
            rd_done_q      <= 1'b0;
            inflight_q     <= 1'b0;
            inflight_eop_q <= 1'b0;
            first_q        <= 1'b0;
            disp_bank_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_ack_q     <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pix_cnt_q      <= pix_cnt_d;
            rd_done_q      <= rd_done_d;
            inflight_q     <= inflight_d;
            inflight_eop_q <= inflight_eop_d;
            first_q        <= first_d;
            disp_bank_q    <= disp_bank_d;
            swap_pending_q <= swap_pending_d;
            swap_ack_q     <= swap_ack_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign rd_en      = rd_en_c;
    assign rd_addr    = {disp_bank_q, pix_cnt_q};
    assign disp_bank  = disp_bank_q;
    assign swap_ack   = swap_ack_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_vga_frame_streamer.sv
module tb_vga_frame_streamer;

    localparam int H = 4;
    localparam int V = 2;
    localparam int NPIX = H * V;
    localparam bit TB_HDR = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0, swap_req = 1'b0, st_ready = 1'b0;
    logic swap_ack, disp_bank, rd_en, st_valid, st_sop, st_eop, frame_done, busy;
    logic [3:0]  rd_addr;
    logic [11:0] rd_data = '0, st_data;

    logic en0 = 1'b0, swap0 = 1'b0, rdy0 = 1'b1;
    logic swap_ack0, disp_bank0, rd_en0, st_valid0, st_sop0, st_eop0, frame_done0, busy0;
    logic [3:0]  rd_addr0;
    logic [11:0] rd_data0 = '0, st_data0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_frame_streamer #(.H_RES(H), .V_RES(V), .PIX_W(12), .ADDR_W(3), .EMIT_HEADER(1'b1)) dut (
        .clk_clk(clk), .reset_reset(rst), .enable(enable), .swap_req(swap_req),
        .swap_ack(swap_ack), .disp_bank(disp_bank), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop),
        .st_eop(st_eop), .st_ready(st_ready), .frame_done(frame_done), .busy(busy));

    vga_frame_streamer #(.H_RES(H), .V_RES(V), .PIX_W(12), .ADDR_W(3), .EMIT_HEADER(1'b0)) dut0 (
        .clk_clk(clk), .reset_reset(rst), .enable(en0), .swap_req(swap0),
        .swap_ack(swap_ack0), .disp_bank(disp_bank0), .rd_en(rd_en0), .rd_addr(rd_addr0),
        .rd_data(rd_data0), .st_data(st_data0), .st_valid(st_valid0), .st_sop(st_sop0),
        .st_eop(st_eop0), .st_ready(rdy0), .frame_done(frame_done0), .busy(busy0));

    // Frame store: each word holds its own address, one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en)  rd_data  <= {8'h00, rd_addr};
        if (rd_en0) rd_data0 <= {8'h00, rd_addr0};
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct packed {
        logic [11:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t       exp_q[$];
    bit          m_idle, m_pending, m_bank, exp_ack, exp_done, prev_stall;
    int          rd_off, outst;
    logic [11:0] prev_data;
    logic        prev_sop, prev_eop;

    always @(negedge clk) begin
        beat_t b;
        bit    xfer_eop;
        if (rst) begin
            exp_q.delete();
            m_idle = 1; m_pending = 0; m_bank = 0; exp_ack = 0; exp_done = 0;
            prev_stall = 0; rd_off = 0; outst = 0;
        end else begin
            xfer_eop = 0;
            check("busy", busy, !m_idle);
            check("disp_bank", disp_bank, m_bank);
            check("swap_ack", swap_ack, exp_ack);
            check("frame_done", frame_done, exp_done);
            if (prev_stall) begin
                check("hold_valid", st_valid, 1);
                check("hold_data", st_data, prev_data);
                check("hold_sop", st_sop, prev_sop);
                check("hold_eop", st_eop, prev_eop);
            end
            if (rd_en) begin
                check("rd_count", rd_off < NPIX, 1);
                check("rd_addr", rd_addr, m_bank * NPIX + rd_off);
                rd_off++;
                outst++;
            end
            if (st_valid && st_ready) begin
                if (exp_q.size() == 0) begin
                    check("beat_extra", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", st_data, b.data);
                    check("beat_sop", st_sop, b.sop);
                    check("beat_eop", st_eop, b.eop);
                    if (!(TB_HDR && b.sop)) outst--;
                    xfer_eop = b.eop;
                end
            end
            check("outstanding", outst <= 2, 1);
            prev_stall = st_valid && !st_ready;
            prev_data = st_data; prev_sop = st_sop; prev_eop = st_eop;

            exp_ack = 0;
            exp_done = xfer_eop;
            if (m_idle) begin
                if (enable) begin
                    if (m_pending || swap_req) begin
                        m_bank = !m_bank;
                        exp_ack = 1;
                        m_pending = 0;
                    end
                    m_idle = 0;
                    rd_off = 0;
                    outst = 0;
                    if (TB_HDR) exp_q.push_back('{12'h000, 1'b1, 1'b0});
                    for (int i = 0; i < NPIX; i++)
                        exp_q.push_back('{12'(m_bank * NPIX + i), (!TB_HDR && i == 0), (i == NPIX - 1)});
                end else if (swap_req) begin
                    m_pending = 1;
                end
            end else begin
                if (swap_req) m_pending = 1;
                if (xfer_eop) m_idle = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        string name;
        int    ready_mode;   // 0 always ready, 1 fixed stall pattern, 2 random
        int    swap1, swap2; // cycle of swap_req pulses, -1 none
        int    drop_cyc;     // enable forced low from this cycle
        int    frame_limit;  // enable dropped once this many frames finished
        int    exp_frames;
        int    exp_bank;
        int    exp_acks;
    } vec_t;

    vec_t vecs[8];

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            0: return 1'b1;
            1: return !((c >= 6 && c <= 10) || c == 12 || c == 14);
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0; swap_req = 1'b0; st_ready = 1'b0; en0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", st_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_bank", disp_bank, 0);
        check("rst_rd_en", rd_en, 0);
        rst = 1'b0;
    endtask

    initial begin
        int frames, acks, n;
        bit got;

        vecs[0] = '{"basic",        0, -1, -1, 999, 2, 2, 0, 0};
        vecs[1] = '{"stall",        1, -1, -1, 999, 2, 2, 0, 0};
        vecs[2] = '{"swap_mid",     0,  6, -1, 999, 2, 2, 1, 1};
        vecs[3] = '{"swap_at_idle", 0,  0, -1, 999, 1, 1, 1, 1};
        vecs[4] = '{"swap_twice",   0,  3,  7, 999, 2, 2, 1, 1};
        vecs[5] = '{"swap_gap",     0, 11, -1, 999, 2, 2, 1, 1};
        vecs[6] = '{"enable_drop",  0, -1, -1,   5, 9, 1, 0, 0};
        vecs[7] = '{"rand_ready",   2,  6, -1, 999, 3, 3, 1, 1};

        for (int r = 0; r < 8; r++) begin
            do_reset();
            frames = 0; acks = 0;
            for (int c = 0; c < 150; c++) begin
                enable   = (c < vecs[r].drop_cyc) && (frames < vecs[r].frame_limit);
                swap_req = (c == vecs[r].swap1) || (c == vecs[r].swap2);
                st_ready = ready_for(vecs[r].ready_mode, c);
                @(posedge clk);
                #1;
                if (frame_done) frames++;
                if (swap_ack) acks++;
            end
            check({vecs[r].name, "_frames"}, frames, vecs[r].exp_frames);
            check({vecs[r].name, "_acks"}, acks, vecs[r].exp_acks);
            check({vecs[r].name, "_bank"}, disp_bank, vecs[r].exp_bank);
            check({vecs[r].name, "_idle"}, busy, 0);
        end

        // Reset in the middle of a frame on bank 1.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            enable = 1'b1; swap_req = (c == 0); st_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        swap_req = 1'b0;
        check("midrst_pre_valid", st_valid, 1);
        check("midrst_pre_data", st_data, NPIX + 5);
        check("midrst_pre_bank", disp_bank, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", st_valid, 0);
        check("midrst_rd_en", rd_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_bank", disp_bank, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(negedge clk);
            if (st_valid && st_ready) begin
                check("restart_sop", st_sop, n == 0);
                check("restart_data", st_data, 0);
                n++;
            end
        end
        check("restart_beats", n, 2);
        enable = 1'b0;
        for (int c = 0; c < 30 && busy; c++) @(posedge clk);
        #1;

        // Headerless variant: SOP rides on pixel 0.
        do_reset();
        en0 = 1'b1;
        n = 0;
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (st_valid0 && rdy0) begin
                check("nohdr_data", st_data0, n);
                check("nohdr_sop", st_sop0, n == 0);
                check("nohdr_eop", st_eop0, n == NPIX - 1);
                if (st_eop0) begin
                    got = 1;
                    en0 = 1'b0;
                end
                n++;
            end
        end
        check("nohdr_beats", n, NPIX);
        repeat (3) @(posedge clk);
        #1;
        check("nohdr_idle", busy0, 0);
        check("nohdr_done", frame_done0, 0);

        // Randomised traffic against the scoreboard.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            enable   = ($urandom_range(0, 15) != 0);
            swap_req = ($urandom_range(0, 7) == 0);
            st_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        enable = 1'b0; swap_req = 1'b0; st_ready = 1'b1;
        for (int c = 0; c < 50 && busy; c++) begin
            @(posedge clk);
            #1;
        end
        check("rand_drain", busy, 0);
        check("rand_leftover", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
